dma_fifo: RTL and testbench

- Synchronous single-clock FIFO used as the DMA data buffer between the device and the MSP memory port.
- Direction is selected per cycle by one wr/rd line; there is no simultaneous push and pop.
- Provides full, empty and a "partially drained" threshold flag so the DMA controller can refill or drain in chunks.
- Provides a one-step rollback for a retried memory address, used when the bus was not ready and the last transfer was invalid.

---
 rtl/dma_fifo_pkg.sv | 24 ++
 rtl/dma_fifo_mem.sv | 30 +++
 rtl/dma_fifo.sv | 146 ++++++++++++++
 tb/tb_dma_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// Shared types and sizing helpers for the DMA data buffer.
package dma_fifo_pkg;

  // Kind of the most recent completed transfer, which a retry may undo.
  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } last_op_t;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

  function automatic int fifo_chunk(input int addr_size, input int div_factor);
    return (1 << addr_size) >> div_factor;
  endfunction

  // Occupancy needs one more bit than the pointers so DEPTH is representable.
  function automatic int occ_width(input int addr_size);
    return addr_size + 1;
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// DEPTH x DATA storage: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module dma_fifo_mem
  import dma_fifo_pkg::*;
#(
  parameter int DATA      = 16,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_waddr,
  input  logic [DATA-1:0]      i_wdata,
  input  logic [ADDR_SIZE-1:0] i_raddr,
  output logic [DATA-1:0]      o_rdata
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA-1:0] r_mem [DEPTH];

  // Write the pushed word at the write pointer.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_fifo.sv
// Single-clock DMA data buffer with one-step rollback for retried transfers.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
//
// last_op  | meaning
// ---------+-----------------------------------------------
// OP_NONE  | previous cycle moved nothing; rollback is a no-op
// OP_PUSH  | previous cycle pushed; rollback retracts wr_ptr
// OP_POP   | previous cycle popped; rollback restores rd_ptr
module dma_fifo
  import dma_fifo_pkg::*;
#(
  parameter int DATA       = 16,
  parameter int ADDR_SIZE  = 5,
  parameter int DIV_FACTOR = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_enable,
  input  logic            fifo_wr_rd,
  input  logic            fifo_old_add_flag,
  input  logic [DATA-1:0] fifo_in,
  output logic [DATA-1:0] fifo_out,
  output logic            full,
  output logic            empty,
  output logic            empty_partial
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic            overflow,
  output logic            underflow
`endif
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);
  localparam int CHUNK = fifo_chunk(ADDR_SIZE, DIV_FACTOR);
  localparam int OCC_W = occ_width(ADDR_SIZE);

  localparam logic [OCC_W-1:0]     C_OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0]     C_OCC_PART = OCC_W'(DEPTH - CHUNK);
  localparam logic [OCC_W-1:0]     C_OCC_ONE  = OCC_W'(1);
  localparam logic [ADDR_SIZE-1:0] C_PTR_ONE  = ADDR_SIZE'(1);

  logic [ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]     r_occ;
  last_op_t             r_last_op;
  logic                 r_flag_d;

  logic [ADDR_SIZE-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [OCC_W-1:0]     w_occ_nxt;
  last_op_t             w_last_op_nxt;

  logic w_push_req, w_pop_req, w_push, w_pop, w_rollback;
  logic w_full, w_empty;
  logic [DATA-1:0] w_rdata;

  assign w_full     = (r_occ == C_OCC_FULL);
  assign w_empty    = (r_occ == '0);
  assign w_push_req = fifo_enable & fifo_wr_rd & ~fifo_old_add_flag;
  assign w_pop_req  = fifo_enable & ~fifo_wr_rd & ~fifo_old_add_flag;
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = w_pop_req & ~w_empty;
  assign w_rollback = fifo_old_add_flag & ~r_flag_d;

  // Register pointers, occupancy, last transfer and previous flag level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_last_op <= OP_NONE;
      r_flag_d  <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_occ     <= w_occ_nxt;
      r_last_op <= w_last_op_nxt;
      r_flag_d  <= fifo_old_add_flag;
    end
  end

  // Next-state: rollback on the rising flag edge only, else one push or pop.
  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_occ_nxt     = r_occ;
    w_last_op_nxt = OP_NONE;
    if (fifo_old_add_flag) begin
      if (w_rollback) begin
        case (r_last_op)
          OP_PUSH: begin
            w_wr_ptr_nxt = r_wr_ptr - C_PTR_ONE;
            w_occ_nxt    = r_occ - C_OCC_ONE;
          end
          OP_POP: begin
            w_rd_ptr_nxt = r_rd_ptr - C_PTR_ONE;
            w_occ_nxt    = r_occ + C_OCC_ONE;
          end
          default: ;
        endcase
      end
    end else if (w_push) begin
      w_wr_ptr_nxt  = r_wr_ptr + C_PTR_ONE;
      w_occ_nxt     = r_occ + C_OCC_ONE;
      w_last_op_nxt = OP_PUSH;
    end else if (w_pop) begin
      w_rd_ptr_nxt  = r_rd_ptr + C_PTR_ONE;
      w_occ_nxt     = r_occ - C_OCC_ONE;
      w_last_op_nxt = OP_POP;
    end
  end

  dma_fifo_mem #(
    .DATA      (DATA),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (fifo_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign fifo_out      = w_empty ? '0 : w_rdata;
  assign full          = w_full;
  assign empty         = w_empty;
  assign empty_partial = (r_occ <= C_OCC_PART);

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow, r_underflow;

  // Sticky error flags for rejected operations; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_req & w_full)  r_overflow  <= 1'b1;
      if (w_pop_req  & w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_dma_fifo.sv
// Bench for dma_fifo: queue-based reference model, directed plus random stimulus.
`timescale 1ns/1ps
module tb_dma_fifo;

  localparam int DEPTH = 32;
  localparam int CHUNK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_enable = 1'b0;
  logic        fifo_wr_rd = 1'b0;
  logic        fifo_old_add_flag = 1'b0;
  logic [15:0] fifo_in = '0;
  logic [15:0] fifo_out;
  logic        full, empty, empty_partial;
`ifdef FIFO_ERR_FLAGS_EN
  logic        overflow, underflow;
`endif

  dma_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_enable       (fifo_enable),
    .fifo_wr_rd        (fifo_wr_rd),
    .fifo_old_add_flag (fifo_old_add_flag),
    .fifo_in           (fifo_in),
    .fifo_out          (fifo_out),
    .full              (full),
    .empty             (empty),
    .empty_partial     (empty_partial)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow          (overflow),
    .underflow         (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: contents as a queue; the last transfer is remembered
  // so a retry can be undone by putting the word back or dropping it.
  logic [15:0] q[$];
  int          m_last;       // 0 none, 1 push, 2 pop
  logic [15:0] m_last_pop;
  bit          m_prev_flag;
  bit          m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 0;
    m_prev_flag = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic model_step(input bit en, input bit wr, input bit fl, input logic [15:0] d);
    logic [15:0] tmp;
    if (fl) begin
      if (!m_prev_flag) begin
        if (m_last == 1) tmp = q.pop_back();
        else if (m_last == 2) q.push_front(m_last_pop);
      end
      m_last = 0;
    end else if (en && wr) begin
      if (q.size() < DEPTH) begin q.push_back(d); m_last = 1; end
      else begin m_last = 0; m_ovf = 1'b1; end
    end else if (en && !wr) begin
      if (q.size() > 0) begin m_last_pop = q.pop_front(); m_last = 2; end
      else begin m_last = 0; m_udf = 1'b1; end
    end else begin
      m_last = 0;
    end
    m_prev_flag = fl;
  endtask

  task automatic check_outputs();
    logic [15:0] head;
    head = (q.size() > 0) ? q[0] : 16'h0000;
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full",  32'(full),  32'(q.size() == DEPTH));
    chk("epart", 32'(empty_partial), 32'(q.size() <= DEPTH - CHUNK));
    chk("dout",  32'(fifo_out), 32'(head));
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf", 32'(overflow),  32'(m_ovf));
    chk("udf", 32'(underflow), 32'(m_udf));
`endif
  endtask

  task automatic cyc(input bit en, input bit wr, input bit fl, input logic [15:0] d);
    rst = 1'b1;
    fifo_enable = en;
    fifo_wr_rd = wr;
    fifo_old_add_flag = fl;
    fifo_in = d;
    @(posedge clk);
    model_step(en, wr, fl, d);
    #1;
    check_outputs();
  endtask

  task automatic rst_cyc(input bit en, input bit wr, input bit fl, input logic [15:0] d);
    rst = 1'b0;
    fifo_enable = en;
    fifo_wr_rd = wr;
    fifo_old_add_flag = fl;
    fifo_in = d;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
  endtask

  task automatic push(input logic [15:0] d); cyc(1, 1, 0, d); endtask
  task automatic pop();                      cyc(1, 0, 0, 16'h0); endtask
  task automatic idle();                     cyc(0, 0, 0, 16'h0); endtask

  initial begin
    int bias;
    bit fl;
    model_reset();

    // 1: reset then idle
    rst_cyc(0, 0, 0, 16'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_epart", 32'(empty_partial), 32'd1);
    chk("rst_dout",  32'(fifo_out), 32'd0);
    idle();

    // 2: fill to full, then an ignored push
    for (int i = 1; i <= DEPTH; i++) push(16'(i));
    chk("full32", 32'(full), 32'd1);
    push(16'hFFFF);
    chk("head_after_ovf", 32'(fifo_out), 32'h0001);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", 32'(overflow), 32'd1);
`endif

    // 3: chunk threshold
    for (int i = 0; i < 3; i++) pop();
    chk("epart_29", 32'(empty_partial), 32'd0);
    pop();
    chk("epart_28", 32'(empty_partial), 32'd1);
    chk("head_5", 32'(fifo_out), 32'h0005);

    // 4: drain in order, then an ignored pop
    for (int i = 5; i <= DEPTH; i++) begin
      chk("drain_order", 32'(fifo_out), 32'(i));
      pop();
    end
    chk("empty_drained", 32'(empty), 32'd1);
    pop();
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_set", 32'(underflow), 32'd1);
`endif

    // 5: rollback of a push, at two pointer positions (second one wraps)
    for (int rep = 0; rep < 2; rep++) begin
      push(16'h000A);
      push(16'h000B);
      for (int k = 0; k < 3; k++) cyc(1, 1, 1, 16'h5555);
      chk("rb_one_word", 32'(q.size()), 32'd1);
      chk("rb_head_a", 32'(fifo_out), 32'h000A);
      push(16'h000C);
      chk("rb_order_a", 32'(fifo_out), 32'h000A);
      pop();
      chk("rb_order_c", 32'(fifo_out), 32'h000C);
      pop();
      // advance pointers so the second pass straddles the wrap point
      for (int k = 0; k < 29; k++) begin push(16'(k)); pop(); end
    end

    // 6: rollback of a pop, then reset mid-burst
    push(16'h0001);
    push(16'h0002);
    pop();
    chk("pop_head2", 32'(fifo_out), 32'h0002);
    cyc(0, 0, 1, 16'h0);
    chk("rbpop_head1", 32'(fifo_out), 32'h0001);
    cyc(1, 0, 1, 16'h0);
    idle();
    chk("rbpop_full_cnt", 32'(empty), 32'd0);
    push(16'h0003);
    rst_cyc(1, 1, 0, 16'h0004);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_dout", 32'(fifo_out), 32'd0);

    // Random phase with shifting push/pop bias so both ends are exercised
    fl = 1'b0;
    bias = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 96 == 0) bias = int'($urandom_range(10, 90));
      if (fl) fl = ($urandom_range(0, 99) < 55);
      else    fl = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 999) < 4) begin
        rst_cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fl, 16'($urandom()));
        fl = 1'b0;
      end else begin
        cyc(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < bias), fl, 16'($urandom()));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
